vx_dispatch_unit: RTL and testbench

- Receiving end of the dispatch interface, one instance per execution unit.
- Collects the per-issue-slot dispatch streams (ISSUE_WIDTH inputs) for its unit and arbitrates among them round-robin.
- Splits each instruction's NUM_THREADS-wide operands into NUM_LANES-wide packets and skips all-inactive packets.
- Presents one registered packet per cycle to the execution unit's execute interface.

---
 rtl/vx_dispatch_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_vx_dispatch_unit.sv | 601 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_unit.sv
// ============================================================================
// vx_dispatch_unit
// ----------------------------------------------------------------------------
// Receiving end of the dispatch interface. There is one instance per execution
// unit. It collects the per-issue-slot dispatch streams, picks one slot
// round-robin, and then splits that slot's warp-wide operands into lane-wide
// packets. Packets whose thread-mask slice is all zero are skipped. One
// registered packet per cycle is presented to the execution unit.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   in_valid[i]     : issue slot i holds an instruction for this unit
//   in_ready[i]     : slot i's instruction is consumed this cycle (its last
//                     packet loads into the output register)
//   in_header       : per-slot opaque header, HDRW bits each
//   in_tmask        : per-slot thread mask, NUM_THREADS bits each
//   in_rsN_data     : per-slot operands, NUM_THREADS*XLEN bits each
//   out_valid/ready : elastic handshake towards the execution unit
//   out_isw         : issue slot the packet came from
//   out_header      : header of the instruction
//   out_tmask       : lane mask slice of this packet
//   out_rsN_data    : lane operand slices of this packet
//   out_pid         : packet index within the warp
//   out_sop/out_eop : first / last emitted packet of the instruction
// ============================================================================
module vx_dispatch_unit #(
    parameter int ISSUE_WIDTH = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int HDRW        = 64,
    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
    localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
    localparam int ISW_W       = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ISSUE_WIDTH-1:0]              in_valid,
    output logic [ISSUE_WIDTH-1:0]              in_ready,
    input  logic [ISSUE_WIDTH*HDRW-1:0]         in_header,
    input  logic [ISSUE_WIDTH*NUM_THREADS-1:0]  in_tmask,
    input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs1_data,
    input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs2_data,
    input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs3_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ISW_W-1:0]                    out_isw,
    output logic [HDRW-1:0]                     out_header,
    output logic [NUM_LANES-1:0]                out_tmask,
    output logic [NUM_LANES*XLEN-1:0]           out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]           out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]           out_rs3_data,
    output logic [PID_W-1:0]                    out_pid,
    output logic                                out_sop,
    output logic                                out_eop
);

    localparam int LANE_W = NUM_LANES * XLEN;
    localparam int WARP_W = NUM_THREADS * XLEN;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [ISW_W-1:0] rr_ptr;
    logic             lock;
    logic [ISW_W-1:0] lock_slot;
    logic [PID_W-1:0] batch_idx;
    logic             sop_flag;

    // Arbitration result while unlocked
    logic [ISW_W-1:0] arb_slot;
    logic             arb_found;

    // Currently selected instruction
    logic [ISW_W-1:0]       sel_slot;
    logic                   sel_valid;
    logic [HDRW-1:0]        sel_header;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [WARP_W-1:0]      sel_rs1;
    logic [WARP_W-1:0]      sel_rs2;
    logic [WARP_W-1:0]      sel_rs3;

    // Packet chosen from the selected instruction
    logic [PID_W-1:0]     pkt_idx;
    logic                 pkt_found;
    logic                 pkt_more;
    logic                 pkt_eop;
    logic [NUM_LANES-1:0] pkt_tmask;
    logic [LANE_W-1:0]    pkt_rs1;
    logic [LANE_W-1:0]    pkt_rs2;
    logic [LANE_W-1:0]    pkt_rs3;

    // Handshake terms
    logic             load_en;
    logic             fire;
    logic             eop_fire;
    logic [ISW_W-1:0] next_rr;

    // ------------------------------------------------------------------
    // Round-robin pick: the lowest valid slot at or after rr_ptr, with
    // wrap-around. With a single slot there is nothing to arbitrate.
    // ------------------------------------------------------------------
    generate
        if (ISSUE_WIDTH == 1) begin : g_single_slot
            assign arb_slot  = '0;
            assign arb_found = in_valid[0];
        end else begin : g_round_robin
            always_comb begin
                int idx;
                idx       = 0;
                arb_slot  = '0;
                arb_found = 1'b0;
                for (int off = 0; off < ISSUE_WIDTH; off++) begin
                    idx = (int'(rr_ptr) + off) % ISSUE_WIDTH;
                    if (!arb_found && in_valid[idx]) begin
                        arb_found = 1'b1;
                        arb_slot  = ISW_W'(idx);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // While locked, the slot that was granted keeps ownership until its
    // last packet has been taken. Otherwise the fresh arbitration result
    // is used. Either way, this block fans out that slot's fields.
    // ------------------------------------------------------------------
    always_comb begin
        sel_slot   = lock ? lock_slot : arb_slot;
        sel_valid  = lock ? in_valid[lock_slot] : arb_found;
        sel_header = in_header[sel_slot*HDRW +: HDRW];
        sel_tmask  = in_tmask[sel_slot*NUM_THREADS +: NUM_THREADS];
        sel_rs1    = in_rs1_data[sel_slot*WARP_W +: WARP_W];
        sel_rs2    = in_rs2_data[sel_slot*WARP_W +: WARP_W];
        sel_rs3    = in_rs3_data[sel_slot*WARP_W +: WARP_W];
    end

    // ------------------------------------------------------------------
    // Find the next packet to emit: the lowest non-empty slice at or above
    // batch_idx. Any non-empty slice above it means this packet is not the
    // last one. A fully inactive mask finds nothing. In that case pkt_idx
    // falls back to batch_idx, which is 0 at the start of every
    // instruction. The result is one pid-0 packet flagged as both sop and
    // eop.
    // ------------------------------------------------------------------
    always_comb begin
        pkt_idx   = batch_idx;
        pkt_found = 1'b0;
        pkt_more  = 1'b0;
        for (int k = 0; k < NUM_PACKETS; k++) begin
            if (sel_tmask[k*NUM_LANES +: NUM_LANES] != '0) begin
                if (pkt_found) begin
                    pkt_more = 1'b1;
                end else if (k >= int'(batch_idx)) begin
                    pkt_found = 1'b1;
                    pkt_idx   = PID_W'(k);
                end
            end
        end
    end

    assign pkt_eop   = ~pkt_more;
    assign pkt_tmask = sel_tmask[pkt_idx*NUM_LANES +: NUM_LANES];
    assign pkt_rs1   = sel_rs1[pkt_idx*LANE_W +: LANE_W];
    assign pkt_rs2   = sel_rs2[pkt_idx*LANE_W +: LANE_W];
    assign pkt_rs3   = sel_rs3[pkt_idx*LANE_W +: LANE_W];

    // The output register takes a new packet whenever it is empty or being
    // drained. The instruction is consumed when its last packet loads.
    assign load_en  = ~out_valid | out_ready;
    assign fire     = sel_valid & load_en;
    assign eop_fire = fire & pkt_eop;
    assign next_rr  = (sel_slot == ISW_W'(ISSUE_WIDTH - 1)) ? '0 : sel_slot + 1'b1;

    // ------------------------------------------------------------------
    // Consume acknowledge. This is one-hot by construction because only the
    // selected slot can see it. It is held low during reset so that an
    // instruction caught mid-flight is replayed rather than lost.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = '0;
        if (eop_fire && !reset) begin
            in_ready[sel_slot] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and batching state. The lock is taken as soon as a slot
    // is selected, even if the output is stalled. This keeps a
    // later-arriving lower slot from stealing the grant while the packet
    // waits. The lock is released together with the rr advance when the
    // eop packet loads. The next grant can then happen on the following
    // cycle without a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_slot <= '0;
            batch_idx <= '0;
            sop_flag  <= 1'b1;
        end else begin
            if (load_en) begin
                out_valid <= sel_valid;
            end
            if (sel_valid) begin
                if (eop_fire) begin
                    lock      <= 1'b0;
                    rr_ptr    <= next_rr;
                    batch_idx <= '0;
                    sop_flag  <= 1'b1;
                end else begin
                    lock      <= 1'b1;
                    lock_slot <= sel_slot;
                    if (fire) begin
                        batch_idx <= pkt_idx + 1'b1;
                        sop_flag  <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output payload register. Its contents only matter while out_valid is
    // high, so it carries no reset. It holds its value whenever the
    // consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fire) begin
            out_isw      <= sel_slot;
            out_header   <= sel_header;
            out_tmask    <= pkt_tmask;
            out_rs1_data <= pkt_rs1;
            out_rs2_data <= pkt_rs2;
            out_rs3_data <= pkt_rs3;
            out_pid      <= pkt_idx;
            out_sop      <= sop_flag;
            out_eop      <= pkt_eop;
        end
    end

endmodule

// File: tb/tb_vx_dispatch_unit.sv
// ============================================================================
// tb_vx_dispatch_unit
// Self-checking bench for vx_dispatch_unit. The directed scenarios cover
// reset, batching, round-robin, backpressure and mid-instruction reset.
// A randomized section compares the output stream against a packet-level
// reference model.
// ============================================================================
module tb_vx_dispatch_unit;

    localparam int IW    = 4;
    localparam int NT    = 4;
    localparam int NL    = 2;
    localparam int XLEN  = 32;
    localparam int HDRW  = 64;
    localparam int NP    = NT / NL;
    localparam int ISW_W = 2;
    localparam int PID_W = 1;

    typedef struct packed {
        logic [31:0]        isw;
        logic [HDRW-1:0]    hdr;
        logic [NL-1:0]      tm;
        logic [NL*XLEN-1:0] d1;
        logic [NL*XLEN-1:0] d2;
        logic [NL*XLEN-1:0] d3;
        logic [31:0]        pid;
        logic               sop;
        logic               eop;
    } pkt_t;

    logic                    clk;
    logic                    reset;
    logic [IW-1:0]           in_valid;
    logic [IW-1:0]           in_ready;
    logic [IW*HDRW-1:0]      in_header;
    logic [IW*NT-1:0]        in_tmask;
    logic [IW*NT*XLEN-1:0]   in_rs1_data;
    logic [IW*NT*XLEN-1:0]   in_rs2_data;
    logic [IW*NT*XLEN-1:0]   in_rs3_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ISW_W-1:0]        out_isw;
    logic [HDRW-1:0]         out_header;
    logic [NL-1:0]           out_tmask;
    logic [NL*XLEN-1:0]      out_rs1_data;
    logic [NL*XLEN-1:0]      out_rs2_data;
    logic [NL*XLEN-1:0]      out_rs3_data;
    logic [PID_W-1:0]        out_pid;
    logic                    out_sop;
    logic                    out_eop;

    // Per-slot stimulus, kept unpacked so the model can read it directly
    logic [HDRW-1:0] hdr [IW];
    logic [NT-1:0]   msk [IW];
    logic [XLEN-1:0] r1  [IW][NT];
    logic [XLEN-1:0] r2  [IW][NT];
    logic [XLEN-1:0] r3  [IW][NT];

    int   checks   = 0;
    int   failures = 0;
    pkt_t exp_q[$];

    vx_dispatch_unit #(
        .ISSUE_WIDTH(IW), .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XLEN), .HDRW(HDRW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_header(in_header), .in_tmask(in_tmask),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_isw(out_isw), .out_header(out_header), .out_tmask(out_tmask),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
        .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flatten the per-slot arrays onto the DUT's packed buses
    always_comb begin
        for (int s = 0; s < IW; s++) begin
            in_header[s*HDRW +: HDRW] = hdr[s];
            in_tmask[s*NT +: NT]      = msk[s];
            for (int t = 0; t < NT; t++) begin
                in_rs1_data[(s*NT+t)*XLEN +: XLEN] = r1[s][t];
                in_rs2_data[(s*NT+t)*XLEN +: XLEN] = r2[s][t];
                in_rs3_data[(s*NT+t)*XLEN +: XLEN] = r3[s][t];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [NT-1:0] m);
        hdr[s] = {$urandom, $urandom};
        msk[s] = m;
        for (int t = 0; t < NT; t++) begin
            r1[s][t] = $urandom;
            r2[s][t] = $urandom;
            r3[s][t] = $urandom;
        end
        in_valid[s] = 1'b1;
    endtask

    // Packet k of slot s as the execution unit should see it
    function automatic pkt_t expect_pkt(input int s, input int k, input logic sop, input logic eop);
        pkt_t p;
        p.isw = 32'(s);
        p.hdr = hdr[s];
        p.tm  = msk[s][k*NL +: NL];
        for (int l = 0; l < NL; l++) begin
            p.d1[l*XLEN +: XLEN] = r1[s][k*NL+l];
            p.d2[l*XLEN +: XLEN] = r2[s][k*NL+l];
            p.d3[l*XLEN +: XLEN] = r3[s][k*NL+l];
        end
        p.pid = 32'(k);
        p.sop = sop;
        p.eop = eop;
        return p;
    endfunction

    // Queue every packet the instruction in slot s should produce
    function automatic void push_instr(input int s);
        int ks[$];
        for (int k = 0; k < NP; k++) begin
            if (msk[s][k*NL +: NL] != '0) ks.push_back(k);
        end
        if (ks.size() == 0) begin
            exp_q.push_back(expect_pkt(s, 0, 1'b1, 1'b1));
        end else begin
            for (int i = 0; i < ks.size(); i++) begin
                exp_q.push_back(expect_pkt(s, ks[i], i == 0, i == ks.size() - 1));
            end
        end
    endfunction

    function automatic pkt_t observed();
        pkt_t p;
        p.isw = 32'(out_isw);
        p.hdr = out_header;
        p.tm  = out_tmask;
        p.d1  = out_rs1_data;
        p.d2  = out_rs2_data;
        p.d3  = out_rs3_data;
        p.pid = 32'(out_pid);
        p.sop = out_sop;
        p.eop = out_eop;
        return p;
    endfunction

    function automatic string fmt(input pkt_t p);
        return $sformatf("isw=%0d pid=%0d sop=%0b eop=%0b tm=%b hdr=%h d1=%h d2=%h d3=%h",
                         p.isw, p.pid, p.sop, p.eop, p.tm, p.hdr, p.d1, p.d2, p.d3);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%b expected=0", out_valid);
        end
        set_slot(0, 4'b1111);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b expected=0000", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold_valid got=%b expected=0", out_valid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_valid got=%b expected=0", out_valid);
        end
    endtask

    task automatic test_full_mask();
        pkt_t e;
        out_ready = 1'b1;
        set_slot(0, 4'b1111);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL full_ready_p0 got=%b expected=0000", in_ready);
        end
        tick();
        e = expect_pkt(0, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 2'b11 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL full_p0 valid=%b got {%s} expected {%s}", out_valid, fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL full_ready_p1 got=%b expected=0001", in_ready);
        end
        tick();
        in_valid[0] = 1'b0;
        e = expect_pkt(0, 1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL full_p1 valid=%b got {%s} expected {%s}", out_valid, fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL full_ready_after got=%b expected=0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_drain valid got=%b expected=0", out_valid);
        end
    endtask

    task automatic test_partial_mask();
        pkt_t e;
        set_slot(2, 4'b1100);
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL partial_ready got=%b expected=0100", in_ready);
        end
        tick();
        in_valid[2] = 1'b0;
        e = expect_pkt(2, 1, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_isw !== 2'd2 || out_pid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL partial_pkt valid=%b got {%s} expected {%s}", out_valid, fmt(observed()), fmt(e));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pkt_t e;
        set_slot(0, 4'b1111);
        set_slot(1, 4'b1111);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL b2b_ready0 got=%b expected=0000", in_ready);
        end
        tick();
        e = expect_pkt(0, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL b2b_s0p0 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL b2b_ready1 got=%b expected=0001", in_ready);
        end
        tick();
        in_valid[0] = 1'b0;
        e = expect_pkt(0, 1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL b2b_s0p1 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL b2b_ready2 got=%b expected=0000", in_ready);
        end
        tick();
        e = expect_pkt(1, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL b2b_s1p0 valid=%b got {%s} expected {%s}", out_valid, fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL b2b_ready3 got=%b expected=0010", in_ready);
        end
        tick();
        in_valid[1] = 1'b0;
        e = expect_pkt(1, 1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL b2b_s1p1 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        tick();
    endtask

    // The pointer sits at 2 here, so slot 3 must win over slot 0
    task automatic test_rr_pointer();
        pkt_t e;
        set_slot(0, 4'b0011);
        set_slot(3, 4'b0011);
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL rr_ready3 got=%b expected=1000", in_ready);
        end
        tick();
        in_valid[3] = 1'b0;
        e = expect_pkt(3, 0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL rr_slot3 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL rr_ready0 got=%b expected=0001", in_ready);
        end
        tick();
        in_valid[0] = 1'b0;
        e = expect_pkt(0, 0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL rr_slot0 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        tick();
    endtask

    task automatic test_backpressure();
        pkt_t e;
        set_slot(1, 4'b1111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        e = expect_pkt(1, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL bp_first got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL bp_ready cycle=%0d got=%b expected=0000", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || observed() !== e) begin
                failures++;
                $display("[TB] FAIL bp_hold cycle=%0d valid=%b got {%s} expected {%s}", c, out_valid, fmt(observed()), fmt(e));
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL bp_resume_ready got=%b expected=0010", in_ready);
        end
        tick();
        in_valid[1] = 1'b0;
        e = expect_pkt(1, 1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL bp_resume got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        tick();
    endtask

    task automatic test_zero_mask();
        pkt_t e;
        set_slot(2, 4'b0000);
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL zero_ready got=%b expected=0100", in_ready);
        end
        tick();
        in_valid[2] = 1'b0;
        e = expect_pkt(2, 0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 2'b00 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL zero_pkt valid=%b got {%s} expected {%s}", out_valid, fmt(observed()), fmt(e));
        end
        tick();
    endtask

    // Slot 3 is mid-instruction when reset hits. Afterwards the pointer is
    // back at 0, so slot 0 goes first and slot 3 replays from pid 0.
    task automatic test_reset_mid();
        pkt_t e;
        set_slot(3, 4'b1111);
        out_ready = 1'b1;
        tick();
        e = expect_pkt(3, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL rstmid_first got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        reset = 1'b1;
        set_slot(0, 4'b1111);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rstmid_ready got=%b expected=0000", in_ready);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_valid got=%b expected=0", out_valid);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rstmid_ready_rel got=%b expected=0000", in_ready);
        end
        tick();
        e = expect_pkt(0, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL rstmid_s0p0 got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        tick();
        in_valid[0] = 1'b0;
        tick();
        e = expect_pkt(3, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("[TB] FAIL rstmid_replay got {%s} expected {%s}", fmt(observed()), fmt(e));
        end
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL rstmid_ready3 got=%b expected=1000", in_ready);
        end
        tick();
        in_valid[3] = 1'b0;
        tick();
    endtask

    // Random slot subsets, masks and stalls against the packet-level model
    task automatic test_random();
        int            rr;
        int            last;
        int            s;
        int            cyc;
        int            idx;
        logic [IW-1:0] vmask;
        logic [IW-1:0] pending;
        logic [IW-1:0] ir;
        bit            acc;
        pkt_t          e;
        reset    = 1'b1;
        in_valid = '0;
        tick();
        reset = 1'b0;
        rr    = 0;
        for (int round = 0; round < 40; round++) begin
            exp_q.delete();
            vmask = IW'($urandom_range(1, 15));
            for (int i = 0; i < IW; i++) begin
                if (vmask[i]) set_slot(i, NT'($urandom_range(0, 15)));
            end
            last = 0;
            for (int off = 0; off < IW; off++) begin
                s = (rr + off) % IW;
                if (vmask[s]) begin
                    push_instr(s);
                    last = s;
                end
            end
            rr      = (last + 1) % IW;
            pending = vmask;
            cyc     = 0;
            while ((pending != '0 || exp_q.size() != 0) && cyc < 100) begin
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                ir = in_ready;
                checks++;
                if ((ir & ~pending) != '0 || $countones(ir) > 1) begin
                    failures++;
                    $display("[TB] FAIL rnd_ready round=%0d got=%b pending=%b", round, ir, pending);
                end
                acc = (out_valid === 1'b1) && out_ready;
                if (acc) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL rnd_extra round=%0d got {%s} expected none", round, fmt(observed()));
                    end else begin
                        e = exp_q.pop_front();
                        if (observed() !== e) begin
                            failures++;
                            $display("[TB] FAIL rnd_pkt round=%0d got {%s} expected {%s}", round, fmt(observed()), fmt(e));
                        end
                    end
                end
                tick();
                if (ir != '0) begin
                    idx = 0;
                    for (int i = 0; i < IW; i++) begin
                        if (ir[i]) idx = i;
                    end
                    checks++;
                    if (out_valid !== 1'b1 || out_eop !== 1'b1 || int'(out_isw) != idx) begin
                        failures++;
                        $display("[TB] FAIL rnd_consume round=%0d valid=%b eop=%b isw=%0d expected slot=%0d", round, out_valid, out_eop, out_isw, idx);
                    end
                    in_valid[idx] = 1'b0;
                    pending[idx]  = 1'b0;
                end
                cyc++;
            end
            if (cyc >= 100) begin
                checks++;
                failures++;
                $display("[TB] FAIL rnd_timeout round=%0d pending=%b queued=%0d", round, pending, exp_q.size());
                in_valid = '0;
                reset    = 1'b1;
                tick();
                reset = 1'b0;
                rr    = 0;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int s = 0; s < IW; s++) begin
            hdr[s] = '0;
            msk[s] = '0;
            for (int t = 0; t < NT; t++) begin
                r1[s][t] = '0;
                r2[s][t] = '0;
                r3[s][t] = '0;
            end
        end
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_back_to_back();
        test_rr_pointer();
        test_backpressure();
        test_zero_mask();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
